// File: rtl/time_display_scan.sv
// time_display_scan: BCD conversion and multiplexed 6-digit 7-segment drive
// for the binary clock core. A sequential double-dabble engine converts the
// hour, minute and seconds counts once per accepted frame. The scan lights
// one digit per slot, blanks a leading zero in the hour tens and blinks the
// whole display while time setting is active.
module time_display_scan #(
    parameter int SCAN_DIV  = 1,
    parameter int BLINK_DIV = 50
) (
    input  logic       clk_i,
    input  logic       reset_ni,
    input  logic [3:0] hour_i,
    input  logic [5:0] minute_i,
    input  logic [5:0] seconds_i,
    input  logic       time_set_i,
    output logic [6:0] seg_o,
    output logic       dp_o,
    output logic [5:0] digit_o
);

    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    // One double-dabble step on {tens, ones, binary}: adjust, then shift.
    function automatic logic [13:0] dd_step(input logic [13:0] sr_in);
        logic [13:0] adj;
        adj = sr_in;
        if (adj[13:10] >= 4'd5) begin
            adj[13:10] = adj[13:10] + 4'd3;
        end else begin
            adj[13:10] = adj[13:10];
        end
        if (adj[9:6] >= 4'd5) begin
            adj[9:6] = adj[9:6] + 4'd3;
        end else begin
            adj[9:6] = adj[9:6];
        end
        return {adj[12:0], 1'b0};
    endfunction

    // Segment pattern for a BCD digit, segments a..g on bits 0..6.
    function automatic logic [6:0] seven_seg(input logic [3:0] bcd);
        logic [6:0] pat;
        case (bcd)
            4'd0:    pat = 7'h3F;
            4'd1:    pat = 7'h06;
            4'd2:    pat = 7'h5B;
            4'd3:    pat = 7'h4F;
            4'd4:    pat = 7'h66;
            4'd5:    pat = 7'h6D;
            4'd6:    pat = 7'h7D;
            4'd7:    pat = 7'h07;
            4'd8:    pat = 7'h7F;
            4'd9:    pat = 7'h6F;
            default: pat = 7'h00;
        endcase
        return pat;
    endfunction

    logic [SW-1:0]     scan_cnt_r, scan_cnt_s;
    logic [2:0]        idx_r, idx_s;
    logic              frame_start_s;
    state_t            state_r, state_s;
    logic [2:0]        bit_cnt_r;
    logic              load_s, shift_s, commit_s;
    logic [13:0]       sr_h_r, sr_m_r, sr_s_r;
    logic [5:0][3:0]   disp_r;
    logic [BW-1:0]     blink_cnt_r, blink_cnt_s;
    logic              blank_r, blank_s;
    logic [3:0]        digit_val_s;
    logic [6:0]        seg_s;
    logic              dp_s;
    logic [5:0]        digit_s;

    // Scan slot counter and digit index advance.
    always_comb begin
        scan_cnt_s = scan_cnt_r;
        idx_s      = idx_r;
        if (scan_cnt_r == SCAN_LAST) begin
            scan_cnt_s = {SW{1'b0}};
            if (idx_r == 3'd5) begin
                idx_s = 3'd0;
            end else begin
                idx_s = idx_r + 3'd1;
            end
        end else begin
            scan_cnt_s = scan_cnt_r + SW'(1);
        end
        frame_start_s = (scan_cnt_r == SCAN_LAST) && (idx_r == 3'd5);
    end

    // Scan state registers.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            scan_cnt_r <= SCAN_LAST;
            idx_r      <= 3'd5;
        end else begin
            scan_cnt_r <= scan_cnt_s;
            idx_r      <= idx_s;
        end
    end

    // Converter FSM state register.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Converter next state: capture on frame start, six shifts, one commit.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (frame_start_s) begin
                    state_s = ST_SHIFT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (bit_cnt_r == 3'd5) begin
                    state_s = ST_COMMIT;
                end else begin
                    state_s = ST_SHIFT;
                end
            end
            ST_COMMIT: state_s = ST_IDLE;
            default:   state_s = ST_IDLE;
        endcase
    end

    // Converter control strobes decoded from the current state.
    always_comb begin
        load_s   = (state_r == ST_IDLE) && frame_start_s;
        shift_s  = (state_r == ST_SHIFT);
        commit_s = (state_r == ST_COMMIT);
    end

    // Converter datapath: shadow capture, shifting and atomic commit.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            bit_cnt_r <= 3'd0;
            sr_h_r    <= 14'd0;
            sr_m_r    <= 14'd0;
            sr_s_r    <= 14'd0;
            disp_r    <= 24'd0;
        end else if (load_s) begin
            bit_cnt_r <= 3'd0;
            sr_h_r    <= {10'd0, hour_i};
            sr_m_r    <= {8'd0, minute_i};
            sr_s_r    <= {8'd0, seconds_i};
        end else if (shift_s) begin
            bit_cnt_r <= bit_cnt_r + 3'd1;
            sr_h_r    <= dd_step(sr_h_r);
            sr_m_r    <= dd_step(sr_m_r);
            sr_s_r    <= dd_step(sr_s_r);
        end else if (commit_s) begin
            disp_r <= {sr_h_r[13:10], sr_h_r[9:6],
                       sr_m_r[13:10], sr_m_r[9:6],
                       sr_s_r[13:10], sr_s_r[9:6]};
        end else begin
            bit_cnt_r <= bit_cnt_r;
        end
    end

    // Blink counter and phase; held visible while time setting is off.
    always_comb begin
        blink_cnt_s = blink_cnt_r;
        blank_s     = blank_r;
        if (!time_set_i) begin
            blink_cnt_s = {BW{1'b0}};
            blank_s     = 1'b0;
        end else if (blink_cnt_r == BLINK_LAST) begin
            blink_cnt_s = {BW{1'b0}};
            blank_s     = ~blank_r;
        end else begin
            blink_cnt_s = blink_cnt_r + BW'(1);
        end
    end

    // Blink state registers.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            blink_cnt_r <= {BW{1'b0}};
            blank_r     <= 1'b0;
        end else begin
            blink_cnt_r <= blink_cnt_s;
            blank_r     <= blank_s;
        end
    end

    // Display drive for the digit about to be selected.
    always_comb begin
        digit_s     = 6'd0;
        digit_val_s = 4'd0;
        case (idx_s)
            3'd0:    begin digit_s = 6'b000001; digit_val_s = disp_r[0]; end
            3'd1:    begin digit_s = 6'b000010; digit_val_s = disp_r[1]; end
            3'd2:    begin digit_s = 6'b000100; digit_val_s = disp_r[2]; end
            3'd3:    begin digit_s = 6'b001000; digit_val_s = disp_r[3]; end
            3'd4:    begin digit_s = 6'b010000; digit_val_s = disp_r[4]; end
            3'd5:    begin digit_s = 6'b100000; digit_val_s = disp_r[5]; end
            default: begin digit_s = 6'b000000; digit_val_s = 4'd0; end
        endcase
        seg_s = seven_seg(digit_val_s);
        dp_s  = (idx_s == 3'd2) || (idx_s == 3'd4);
        if ((idx_s == 3'd5) && (digit_val_s == 4'd0)) begin
            seg_s = 7'h00;
        end else begin
            seg_s = seg_s;
        end
        if (blank_s) begin
            seg_s = 7'h00;
            dp_s  = 1'b0;
        end else begin
            dp_s = dp_s;
        end
    end

    // Registered display outputs.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            seg_o   <= 7'h00;
            dp_o    <= 1'b0;
            digit_o <= 6'd0;
        end else begin
            seg_o   <= seg_s;
            dp_o    <= dp_s;
            digit_o <= digit_s;
        end
    end

endmodule
